// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port arbiter sharing one ready/valid block-RAM port
module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_p0_req_valid,
    input  logic                    i_p1_req_valid,
    output logic                    o_p0_req_ready,
    output logic                    o_p1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_p0_addr,
    input  logic [ADDR_WIDTH-1:0]   i_p1_addr,
    input  logic                    i_p0_we,
    input  logic                    i_p1_we,
    input  logic [DATA_WIDTH-1:0]   i_p0_wdata,
    input  logic [DATA_WIDTH-1:0]   i_p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_p0_be,
    input  logic [DATA_WIDTH/8-1:0] i_p1_be,
    output logic                    o_p0_rsp_valid,
    output logic                    o_p1_rsp_valid,
    input  logic                    i_p0_rsp_ready,
    input  logic                    i_p1_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_p0_rdata,
    output logic [DATA_WIDTH-1:0]   o_p1_rdata,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_data,
    output logic [DATA_WIDTH/8-1:0] o_mem_byte_write_enable,
    output logic                    o_mem_wr_valid,
    input  logic                    i_mem_wr_ready,
    output logic                    o_mem_rd_ready,
    input  logic                    i_mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_data
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
    logic                    port_q;
    logic                    last_grant;
    logic                    wr_valid_q;
    logic                    rd_ready_q;
    logic                    rsp_valid0_q;
    logic                    rsp_valid1_q;
    logic                    grant1;
    logic                    accept;
    logic                    rsp_taken;

    // grant1 only ever rises when port 1 is actually requesting
    always_comb begin
        grant1 = i_p1_req_valid;
        if (i_p0_req_valid && i_p1_req_valid)
            grant1 = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
    end

    assign accept         = i_rst_n && (state == IDLE) && (i_p0_req_valid || i_p1_req_valid);
    assign o_p0_req_ready = accept && !grant1;
    assign o_p1_req_ready = accept && grant1;
    assign rsp_taken      = port_q ? i_p1_rsp_ready : i_p0_rsp_ready;

    assign o_mem_addr              = addr_q;
    assign o_mem_data              = wdata_q;
    assign o_mem_byte_write_enable = be_q;
    assign o_mem_wr_valid          = wr_valid_q;
    assign o_mem_rd_ready          = rd_ready_q;
    assign o_p0_rsp_valid          = rsp_valid0_q;
    assign o_p1_rsp_valid          = rsp_valid1_q;
    assign o_p0_rdata              = rdata0_q;
    assign o_p1_rdata              = rdata1_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            port_q       <= 1'b0;
            last_grant   <= 1'b1;
            wr_valid_q   <= 1'b0;
            rd_ready_q   <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        port_q     <= grant1;
                        last_grant <= grant1;
                        addr_q     <= grant1 ? i_p1_addr  : i_p0_addr;
                        wdata_q    <= grant1 ? i_p1_wdata : i_p0_wdata;
                        if (grant1 ? i_p1_we : i_p0_we) begin
                            be_q       <= grant1 ? i_p1_be : i_p0_be;
                            wr_valid_q <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            be_q       <= '0;
                            rd_ready_q <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (i_mem_wr_ready) begin
                        wr_valid_q <= 1'b0;
                        be_q       <= '0;
                        state      <= IDLE;
                    end
                end
                READ: begin
                    if (i_mem_rd_valid) begin
                        rd_ready_q <= 1'b0;
                        if (port_q) begin
                            rdata1_q     <= i_mem_data;
                            rsp_valid1_q <= 1'b1;
                        end else begin
                            rdata0_q     <= i_mem_data;
                            rsp_valid0_q <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // rdata registers are left untouched so the last value stays visible
                    if (rsp_taken) begin
                        rsp_valid0_q <= 1'b0;
                        rsp_valid1_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - scoreboard bench for bram_arbiter (round-robin and fixed-priority copies)
module tb_bram_arbiter;
    logic clk, rst_n;
    logic p0_v, p1_v, p0_we, p1_we, p0_rr, p1_rr;
    logic [9:0] p0_addr, p1_addr;
    logic [31:0] p0_wd, p1_wd;
    logic [3:0] p0_be, p1_be;
    logic m_wrdy;

    logic p0_rdy [2];
    logic p1_rdy [2];
    logic p0_rv [2];
    logic p1_rv [2];
    logic [31:0] p0_rd [2];
    logic [31:0] p1_rd [2];
    logic [9:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0] m_be [2];
    logic m_wv [2];
    logic m_rr [2];

    int n_tests = 0;
    int n_fail = 0;
    int cycle = 0;

    bit gq0[$], gq1[$];
    logic [32:0] rq0[$], rq1[$];

    assign m_wrdy = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // instance 0 is round-robin, instance 1 is fixed-priority; each has its own memory model
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic rv_q;
        logic [31:0] rd_q;
        logic [31:0] mem [1024];

        bram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .FIXED_PRIO(g)) dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_p0_req_valid(p0_v), .i_p1_req_valid(p1_v),
            .o_p0_req_ready(p0_rdy[g]), .o_p1_req_ready(p1_rdy[g]),
            .i_p0_addr(p0_addr), .i_p1_addr(p1_addr),
            .i_p0_we(p0_we), .i_p1_we(p1_we),
            .i_p0_wdata(p0_wd), .i_p1_wdata(p1_wd),
            .i_p0_be(p0_be), .i_p1_be(p1_be),
            .o_p0_rsp_valid(p0_rv[g]), .o_p1_rsp_valid(p1_rv[g]),
            .i_p0_rsp_ready(p0_rr), .i_p1_rsp_ready(p1_rr),
            .o_p0_rdata(p0_rd[g]), .o_p1_rdata(p1_rd[g]),
            .o_mem_addr(m_addr[g]), .o_mem_data(m_wdata[g]),
            .o_mem_byte_write_enable(m_be[g]),
            .o_mem_wr_valid(m_wv[g]), .i_mem_wr_ready(m_wrdy),
            .o_mem_rd_ready(m_rr[g]), .i_mem_rd_valid(rv_q), .i_mem_data(rd_q)
        );

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv_q <= 1'b0;
                rd_q <= '0;
                mem[10'h000] <= 32'h0000_1137;
                mem[10'h010] <= 32'h1010_1010;
                mem[10'h020] <= 32'h2020_2020;
                mem[10'h030] <= 32'h3030_3030;
                mem[10'h040] <= 32'hAAAA_AAAA;
            end else begin
                rv_q <= m_rr[g] && !rv_q;
                rd_q <= mem[m_addr[g]];
                if (m_wv[g])
                    for (int b = 0; b < 4; b++)
                        if (m_be[g][b]) mem[m_addr[g]][8*b +: 8] <= m_wdata[g][8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_grant(input int k, input bit port);
        bit e;
        if ((k == 0 && gq0.size() == 0) || (k == 1 && gq1.size() == 0)) begin
            check($sformatf("unexpected_grant_i%0d", k), 64'(port), 64'd2);
        end else begin
            e = (k == 0) ? gq0.pop_front() : gq1.pop_front();
            check($sformatf("grant_port_i%0d", k), 64'(port), 64'(e));
        end
    endtask

    task automatic pop_rsp(input int k, input bit port, input logic [31:0] data);
        logic [32:0] e;
        if ((k == 0 && rq0.size() == 0) || (k == 1 && rq1.size() == 0)) begin
            check($sformatf("unexpected_rsp_i%0d", k), {port, data}, 64'h1_0000_0000_0);
        end else begin
            e = (k == 0) ? rq0.pop_front() : rq1.pop_front();
            check($sformatf("rsp_port_i%0d", k), 64'(port), 64'(e[32]));
            check($sformatf("rsp_data_i%0d", k), 64'(data), 64'(e[31:0]));
        end
    endtask

    // monitor: every accepted request and every taken response is matched against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (p0_rdy[k] && p1_rdy[k]) check($sformatf("dual_ready_i%0d", k), 64'd1, 64'd0);
                if (p0_rv[k] && p1_rv[k]) check($sformatf("dual_rsp_i%0d", k), 64'd1, 64'd0);
                if (p0_rdy[k] && p0_v) pop_grant(k, 1'b0);
                if (p1_rdy[k] && p1_v) pop_grant(k, 1'b1);
                if (p0_rv[k] && p0_rr) pop_rsp(k, 1'b0, p0_rd[k]);
                if (p1_rv[k] && p1_rr) pop_rsp(k, 1'b1, p1_rd[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_both(input bit gp, input bit has_rsp, input logic [31:0] d);
        gq0.push_back(gp);
        gq1.push_back(gp);
        if (has_rsp) begin
            rq0.push_back({gp, d});
            rq1.push_back({gp, d});
        end
    endtask

    task automatic wait_grant(output int cyc);
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (p0_rdy[0] || p1_rdy[0]) begin
                cyc = cycle;
                return;
            end
        end
        check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gq0.size() + gq1.size() + rq0.size() + rq1.size() == 0) break;
        end
        check("drain_queues", 64'(gq0.size() + gq1.size() + rq0.size() + rq1.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ctl_i%0d", tag, k),
                  64'({p0_rdy[k], p1_rdy[k], p0_rv[k], p1_rv[k], m_wv[k], m_rr[k]}), 64'd0);
            check($sformatf("%s_rdata_i%0d", tag, k), {p0_rd[k], p1_rd[k]}, 64'd0);
            check($sformatf("%s_mem_i%0d", tag, k), {14'd0, m_addr[k], m_wdata[k], m_be[k]}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c [5];
        int cs;
        rst_n = 1'b0;
        {p0_v, p1_v, p0_we, p1_we, p0_rr, p1_rr} = '0;
        p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0; p0_be = '0; p1_be = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");

        // p0 read of address 0: ready at T, rd_ready at T+1, response at T+3
        tick();
        p0_v = 1'b1; p0_addr = 10'h000; p0_we = 1'b0; p0_rr = 1'b1; p1_rr = 1'b1;
        push_both(1'b0, 1'b1, 32'h0000_1137);
        @(negedge clk);
        check("t1_p0_ready_T", 64'(p0_rdy[0]), 64'd1);
        tick();
        p0_v = 1'b0; p0_addr = 10'h3FF;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t1_rd_ready_T1_i%0d", k), 64'(m_rr[k]), 64'd1);
            check($sformatf("t1_addr_i%0d", k), 64'(m_addr[k]), 64'h000);
            check($sformatf("t1_be_wv_i%0d", k), 64'({m_be[k], m_wv[k]}), 64'd0);
        end
        @(negedge clk);
        check("t1_no_rsp_T2", 64'(p0_rv[0]), 64'd0);
        @(negedge clk);
        check("t1_rsp_valid_T3", 64'(p0_rv[0]), 64'd1);
        check("t1_rdata_T3", 64'(p0_rd[0]), 64'h1137);
        @(negedge clk);
        check("t1_rsp_drop", 64'(p0_rv[0]), 64'd0);
        check("t1_rdata_held", 64'(p0_rd[0]), 64'h1137);
        check("t1_rd_ready_low", 64'(m_rr[0]), 64'd0);

        // p1 partial write, then read back the merged word
        tick();
        p1_v = 1'b1; p1_we = 1'b1; p1_addr = 10'h040; p1_wd = 32'h4142_4344; p1_be = 4'b0011;
        push_both(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("t2_p1_ready", 64'(p1_rdy[0]), 64'd1);
        tick();
        p1_v = 1'b0; p1_wd = 32'hDEAD_BEEF; p1_be = 4'b1111; p1_addr = 10'h3FF;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t2_wr_valid_i%0d", k), 64'(m_wv[k]), 64'd1);
            check($sformatf("t2_wdata_i%0d", k), 64'(m_wdata[k]), 64'h4142_4344);
            check($sformatf("t2_be_addr_i%0d", k), 64'({m_be[k], m_addr[k]}), {50'd0, 4'b0011, 10'h040});
        end
        @(negedge clk);
        check("t2_wr_done", 64'(m_wv[0]), 64'd0);
        tick();
        p1_v = 1'b1; p1_we = 1'b0; p1_addr = 10'h040;
        push_both(1'b1, 1'b1, 32'hAAAA_4344);
        wait_grant(cs);
        tick();
        p1_v = 1'b0;
        drain();

        // contention: round-robin alternates from p0, fixed priority keeps p1
        tick();
        p0_v = 1'b1; p0_addr = 10'h010; p0_we = 1'b0;
        p1_v = 1'b1; p1_addr = 10'h020; p1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gq0.push_back(i[0]);
            rq0.push_back({i[0], i[0] ? 32'h2020_2020 : 32'h1010_1010});
            gq1.push_back(1'b1);
            rq1.push_back({1'b1, 32'h2020_2020});
        end
        gq0.push_back(1'b0); rq0.push_back({1'b0, 32'h1010_1010});
        gq1.push_back(1'b0); rq1.push_back({1'b0, 32'h1010_1010});
        for (int i = 0; i < 4; i++) begin
            wait_grant(c[i]);
            if (i > 0) check($sformatf("t3_cadence_%0d", i), 64'(c[i] - c[i-1]), 64'd4);
        end
        tick();
        p1_v = 1'b0;
        wait_grant(c[4]);
        check("t3_cadence_4", 64'(c[4] - c[3]), 64'd4);
        tick();
        p0_v = 1'b0;
        drain();

        // stalled p0 response holds the arbiter while p1 waits
        tick();
        p0_rr = 1'b0;
        p0_v = 1'b1; p0_addr = 10'h010;
        push_both(1'b0, 1'b1, 32'h1010_1010);
        push_both(1'b1, 1'b1, 32'h2020_2020);
        wait_grant(cs);
        tick();
        p0_v = 1'b0;
        p1_v = 1'b1; p1_addr = 10'h020; p1_we = 1'b0;
        for (int i = 0; i < 20 && !p0_rv[0]; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check($sformatf("t4_stall_%0d_i%0d", i, k),
                      {p0_rv[k], p1_rdy[k], p0_rd[k]}, {1'b1, 1'b0, 32'h1010_1010});
        end
        tick();
        p0_rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("t4_p1_granted_i%0d", k), 64'(p1_rdy[k]), 64'd1);
        tick();
        p1_v = 1'b0;
        drain();

        // asynchronous reset in the middle of a p0 read
        tick();
        p0_v = 1'b1; p0_addr = 10'h030;
        gq0.push_back(1'b0); gq1.push_back(1'b0);
        wait_grant(cs);
        tick();
        p0_v = 1'b0;
        #2;
        check("t5_mid_read", 64'(m_rr[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0_v = 1'b1; p0_addr = 10'h000;
        p1_v = 1'b1; p1_addr = 10'h010;
        gq0.push_back(1'b0); rq0.push_back({1'b0, 32'h0000_1137});
        gq1.push_back(1'b1); rq1.push_back({1'b1, 32'h1010_1010});
        wait_grant(cs);
        tick();
        p0_v = 1'b0; p1_v = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
